// File: rtl/jtdsp16_rom_aau_pkg.sv
// Shared constants for the jtdsp16 ROM address unit.
// B-field flow codes match the ones jtdsp16_ctrl decodes.
package jtdsp16_rom_aau_pkg;

  localparam logic [2:0] B_RET     = 3'd0;
  localparam logic [2:0] B_IRET    = 3'd1;
  localparam logic [2:0] B_GOTO_PT = 3'd2;
  localparam logic [2:0] B_CALL_PT = 3'd3;

  localparam logic [15:0] RST_ADDR = 16'h0000;

  function automatic logic [15:0] ja_tgt(
    input logic [15:0] pc,
    input logic [11:0] i
  );
    return {pc[15:12], i};
  endfunction

endpackage

// File: rtl/jtdsp16_rom_aau_if.sv
// Decoder <-> ROM address unit bundle.
// master = decoder side, slave = address unit.
interface jtdsp16_rom_aau_if;
  logic        goto_ja;
  logic        goto_b;
  logic        call_ja;
  logic        icall;
  logic        post_inc;
  logic        pc_halt;
  logic        ext_irq;
  logic [11:0] i_field;
  logic [2:0]  b_field;
  logic        pt_load;
  logic [15:0] pt_din;
  logic [15:0] rom_addr;
  logic [15:0] pr;
  logic [15:0] pi;
  logic [15:0] pt;
  logic        in_irq;

  modport master (
    output goto_ja, goto_b, call_ja, icall,
    output post_inc, pc_halt, ext_irq,
    output i_field, b_field, pt_load, pt_din,
    input  rom_addr, pr, pi, pt, in_irq
  );

  modport slave (
    input  goto_ja, goto_b, call_ja, icall,
    input  post_inc, pc_halt, ext_irq,
    input  i_field, b_field, pt_load, pt_din,
    output rom_addr, pr, pi, pt, in_irq
  );
endinterface

// File: rtl/jtdsp16_rom_aau.sv
// jtdsp16 ROM address unit: pc/pr/pi/pt and
// the interrupt entry/exit sequencing.
module jtdsp16_rom_aau
  import jtdsp16_rom_aau_pkg::*;
#(
  parameter logic [15:0] IRQ_VECTOR   = 16'h0001,
  parameter logic [15:0] ICALL_VECTOR = 16'h0002
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  jtdsp16_rom_aau_if.slave bus
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] pr_q, pr_d;
  logic [15:0] pi_q, pi_d;
  logic [15:0] pt_q, pt_d;
  logic        in_irq_q, in_irq_d;
  logic        irq_pend_q, irq_pend_d;
  logic [15:0] pc_inc;

  assign pc_inc = pc_q + 16'd1;

  always_comb begin
    pc_d       = pc_q;
    pr_d       = pr_q;
    pi_d       = pi_q;
    pt_d       = pt_q;
    in_irq_d   = in_irq_q;
    irq_pend_d = irq_pend_q;
    if (cen) begin
      // level request latched only outside a service routine
      if (bus.ext_irq && !in_irq_q)
        irq_pend_d = 1'b1;
      if (bus.pc_halt) begin
        pc_d = pc_q;
      end else if (bus.goto_b) begin
        case (bus.b_field)
          B_RET: pc_d = pr_q;
          B_IRET: begin
            pc_d     = pi_q;
            in_irq_d = 1'b0;
          end
          B_GOTO_PT: pc_d = pt_q;
          B_CALL_PT: begin
            pr_d = pc_q;
            pc_d = pt_q;
          end
          default: pc_d = pc_inc;
        endcase
      end else if (bus.call_ja) begin
        pr_d = pc_q;
        pc_d = ja_tgt(pc_q, bus.i_field);
      end else if (bus.goto_ja) begin
        pc_d = ja_tgt(pc_q, bus.i_field);
      end else if (bus.icall) begin
        pr_d = pc_q;
        pc_d = ICALL_VECTOR;
      end else if (irq_pend_q) begin
        pi_d       = pc_q;
        pc_d       = IRQ_VECTOR;
        in_irq_d   = 1'b1;
        irq_pend_d = 1'b0;
      end else begin
        pc_d = pc_inc;
      end
      if (bus.pt_load)
        pt_d = bus.pt_din;
      else if (bus.post_inc)
        pt_d = pt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RST_ADDR;
      pr_q       <= 16'h0000;
      pi_q       <= 16'h0000;
      pt_q       <= 16'h0000;
      in_irq_q   <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pr_q       <= pr_d;
      pi_q       <= pi_d;
      pt_q       <= pt_d;
      in_irq_q   <= in_irq_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.pr       = pr_q;
  assign bus.pi       = pi_q;
  assign bus.pt       = pt_q;
  assign bus.in_irq   = in_irq_q;

endmodule
